temporal_buffer_wrapper: RTL and testbench

Holds the clause sets of the last NSAT variable flips in the WalkSAT datapath, one slot per flip. Each slot combines the flipped literal with the literals fetched from the clause table for every clause containing that variable. It sits between clause-table lookup and the clause-evaluation stage. Downstream logic selects any slot to read by index.

---
 rtl/temporal_buffer_pkg.sv | 33 +++
 rtl/temporal_buffer.sv | 43 ++++
 rtl/temporal_buffer_wrapper.sv | 62 ++++++
 tb/tb_temporal_buffer_wrapper.sv | 128 ++++++++++++
 4 files changed

// File: rtl/temporal_buffer_pkg.sv
// Shared widths and per-clause offset helpers for the temporal clause buffer.
// Functions take the structural parameters so every instance computes its own layout.
package temporal_buffer_pkg;

    localparam int unsigned DefaultNsat = 3;
    localparam int unsigned DefaultLitAddrWidth = 11;
    localparam int unsigned DefaultMaxClauses = 20;

    function automatic int unsigned lit_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned slot_width(input int unsigned nsat, input int unsigned m,
                                               input int unsigned w);
        return nsat * m * w;
    endfunction

    // Base of clause i inside a packed slot.
    function automatic int unsigned clause_offset(input int unsigned i, input int unsigned nsat,
                                                  input int unsigned w);
        return i * nsat * w;
    endfunction

    // Base of clause i inside the clause-table input bus.
    function automatic int unsigned table_offset(input int unsigned i, input int unsigned nsat,
                                                 input int unsigned w);
        return i * (nsat - 1) * w;
    endfunction

    localparam int unsigned LitWidth = lit_width(DefaultLitAddrWidth);
    localparam int unsigned SlotWidth = slot_width(DefaultNsat, DefaultMaxClauses, LitWidth);

endpackage

// File: rtl/temporal_buffer.sv
// One slot of the temporal buffer: M stored clauses with write enable and synchronous clear.
module temporal_buffer
    import temporal_buffer_pkg::*;
#(
    parameter int unsigned NSAT = 3,
    parameter int unsigned W    = 12,
    parameter int unsigned M    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [NSAT*M*W-1:0]   clauses_i,
    output logic [NSAT*M*W-1:0]   clauses_o
);

    logic [NSAT*W-1:0] stored_clauses_q [M];
    logic [NSAT*W-1:0] stored_clauses_d [M];

    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            stored_clauses_d[i] = stored_clauses_q[i];
            if (we_i) begin
                stored_clauses_d[i] = clauses_i[clause_offset(i, NSAT, W) +: NSAT*W];
            end
        end
    end

    // Clear wins over write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(M); i++) begin
            if (reset) begin
                stored_clauses_q[i] <= '0;
            end else begin
                stored_clauses_q[i] <= stored_clauses_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(M); g++) begin : g_out
        assign clauses_o[g*NSAT*W +: NSAT*W] = stored_clauses_q[g];
    end

endmodule

// File: rtl/temporal_buffer_wrapper.sv
// Ring of NSAT clause-set slots for the last flips: index-addressed write every cycle,
// combinational index-addressed read with zero output for out-of-range indices.
module temporal_buffer_wrapper
    import temporal_buffer_pkg::*;
#(
    parameter int unsigned NSAT                     = 3,
    parameter int unsigned LITERAL_ADDRESS_WIDTH    = 11,
    parameter int unsigned MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int unsigned NSAT_BITS                = 2
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic [NSAT_BITS-1:0]                                           write_index_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0]  flipped_literal_multi_i,
    input  logic [(NSAT-1)*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0]
                                                                           clause_table_literals_multi_i,
    input  logic [NSAT_BITS-1:0]                                           read_index_i,
    output logic [NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_multi_o
);

    localparam int unsigned M  = MAX_CLAUSES_PER_VARIABLE;
    localparam int unsigned W  = lit_width(LITERAL_ADDRESS_WIDTH);
    localparam int unsigned CW = slot_width(NSAT, M, W);

    logic [CW-1:0]   packed_clauses;
    logic [NSAT-1:0] slot_we;
    logic [CW-1:0]   slot_data [NSAT];

    // Flipped literal sits in the least significant position of each clause.
    for (genvar i = 0; i < int'(M); i++) begin : g_pack
        assign packed_clauses[clause_offset(i, NSAT, W) +: W] =
            flipped_literal_multi_i[i*W +: W];
        assign packed_clauses[clause_offset(i, NSAT, W) + W +: (NSAT-1)*W] =
            clause_table_literals_multi_i[table_offset(i, NSAT, W) +: (NSAT-1)*W];
    end

    for (genvar s = 0; s < int'(NSAT); s++) begin : g_slot
        assign slot_we[s] = (write_index_i == NSAT_BITS'(s));

        temporal_buffer #(
            .NSAT (NSAT),
            .W    (W),
            .M    (M)
        ) u_temporal_buffer (
            .clk       (clk),
            .reset     (reset),
            .we_i      (slot_we[s]),
            .clauses_i (packed_clauses),
            .clauses_o (slot_data[s])
        );
    end

    always_comb begin
        clause_multi_o = '0;
        for (int s = 0; s < int'(NSAT); s++) begin
            if (read_index_i == NSAT_BITS'(s)) begin
                clause_multi_o = slot_data[s];
            end
        end
    end

endmodule

// File: tb/tb_temporal_buffer_wrapper.sv
// Scoreboard bench for temporal_buffer_wrapper in the NSAT=3, W=5, M=1 configuration.
module tb_temporal_buffer_wrapper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  write_index_i = '0;
    logic [4:0]  flipped_literal_multi_i = '0;
    logic [9:0]  clause_table_literals_multi_i = '0;
    logic [1:0]  read_index_i = '0;
    logic [14:0] clause_multi_o;

    temporal_buffer_wrapper #(
        .NSAT                     (3),
        .LITERAL_ADDRESS_WIDTH    (4),
        .MAX_CLAUSES_PER_VARIABLE (1),
        .NSAT_BITS                (2)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .write_index_i                 (write_index_i),
        .flipped_literal_multi_i       (flipped_literal_multi_i),
        .clause_table_literals_multi_i (clause_table_literals_multi_i),
        .read_index_i                  (read_index_i),
        .clause_multi_o                (clause_multi_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [14:0] exp_q [$];
    string       name_q [$];
    logic [14:0] model [3];

    // Monitor: output is sampled late in the low phase, before the next rising edge.
    always @(negedge clk) begin
        logic [14:0] e;
        string n;
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (clause_multi_o !== e) begin
                fails++;
                $display("FAIL %s: read_index=%0d got %h expected %h",
                         n, read_index_i, clause_multi_o, e);
            end
        end
    end

    // One clock of stimulus; the expected output is the slot contents before this edge.
    task automatic cycle(input logic rst, input logic [1:0] widx, input logic [14:0] data,
                         input logic [1:0] ridx, input bit chk, input string name);
        @(negedge clk);
        reset = rst;
        write_index_i = widx;
        flipped_literal_multi_i = data[4:0];
        clause_table_literals_multi_i = data[14:5];
        read_index_i = ridx;
        if (chk) begin
            exp_q.push_back((ridx < 2'd3) ? model[ridx] : 15'h0);
            name_q.push_back(name);
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) model[i] = 15'h0;
        end else if (widx < 2'd3) begin
            model[widx] = data;
        end
    endtask

    task automatic read_all(input string name);
        for (int r = 0; r < 4; r++) cycle(1'b0, 2'd3, 15'h0, 2'(r), 1'b1, name);
    endtask

    initial begin
        logic [14:0] d;
        logic [1:0]  w, r;
        for (int i = 0; i < 3; i++) model[i] = 15'h0;

        cycle(1'b1, 2'd0, 15'h0, 2'd0, 1'b0, "init");
        for (int r0 = 0; r0 < 4; r0++) cycle(1'b1, 2'd0, 15'h7FFF, 2'(r0), 1'b1, "reset");

        cycle(1'b0, 2'd0, {10'h155, 5'h03}, 2'd0, 1'b1, "basic_w0");
        cycle(1'b0, 2'd1, {10'h000, 5'h1F}, 2'd0, 1'b1, "basic_w1");
        read_all("basic_read");
        if (model[0] !== 15'h2AA3 || model[1] !== 15'h001F) begin
            $display("FAIL model_pack: got %h/%h expected 2aa3/001f", model[0], model[1]);
            fails++;
        end

        for (int k = 0; k < 10; k++) begin
            for (int s = 0; s < 3; s++) begin
                d = 15'($urandom);
                cycle(1'b0, 2'(s), d, 2'($urandom_range(0, 3)), 1'b1, "fill");
            end
            cycle(1'b0, 2'd3, 15'($urandom), 2'($urandom_range(0, 3)), 1'b1, "fill_read");
        end
        cycle(1'b0, 2'd3, 15'h0, 2'd2, 1'b1, "fill_slot2");

        cycle(1'b0, 2'd1, 15'h1234, 2'd1, 1'b1, "overwrite_a");
        cycle(1'b0, 2'd1, 15'h7FFF, 2'd1, 1'b1, "overwrite_b");
        read_all("overwrite_read");

        cycle(1'b0, 2'd3, 15'h7FFF, 2'd3, 1'b1, "oor_write");
        read_all("oor_read");

        for (int s = 0; s < 3; s++) cycle(1'b0, 2'(s), 15'($urandom) | 15'h1, 2'(s), 1'b1, "prefill");
        cycle(1'b1, 2'd0, 15'h5A5A, 2'd0, 1'b1, "mid_reset");
        read_all("after_reset");

        for (int k = 0; k < 200; k++) begin
            w = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 19) == 0), w, 15'($urandom), r, 1'b1, "random");
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
